// File: rtl/vga_frame_capture.sv
// VGA receiver: recovers pixel timing from sync pulses sampled in clk, writes active pixels to a frame buffer,
// and keeps a per-frame checksum and frame count. Define VGA_CAP_ERR_EN to build the line/frame length checkers.
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_clk,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic [23:0]       rgb,
  input  logic              cap_en,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic [31:0]       frame_sum,
  output logic [15:0]       frame_cnt,
  output logic              busy,
  output logic              h_err,
  output logic              v_err
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  localparam logic [11:0] H_START   = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_STOP    = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_START   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_STOP    = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] LAST_COL  = 12'(H_ACTIVE - 1);
  localparam logic [10:0] LAST_LINE = 11'(V_ACTIVE - 1);

  state_t state_reg, state_next;

  logic              vclk_q, hs_q, vs_q;
  logic              strobe, hfall, vfall;
  logic [11:0]       hcnt_reg, hcnt_next;
  logic [10:0]       vcnt_reg, vcnt_next;
  logic [11:0]       col;
  logic [10:0]       line;
  logic              active_pix, cap_pix, is_last;
  logic [ADDR_W-1:0] addr_next;

  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [23:0]       wr_data_reg;
  logic              last_reg;
  logic              frame_done_reg;
  logic [31:0]       frame_sum_reg;
  logic [15:0]       frame_cnt_reg;
  logic [31:0]       acc_reg;

  // vga_clk is plain data here: its rising edge marks one pixel slot
  assign strobe = vga_clk & ~vclk_q;
  assign hfall  = strobe & ~h_sync & hs_q;
  assign vfall  = strobe & ~v_sync & vs_q;

  always_comb begin
    hcnt_next = hcnt_reg;
    vcnt_next = vcnt_reg;
    if (strobe) begin
      if (hfall)
        hcnt_next = '0;
      else if (hcnt_reg != '1)
        hcnt_next = hcnt_reg + 12'd1;
      if (vfall)
        vcnt_next = '0;
      else if (hfall && (vcnt_reg != '1))
        vcnt_next = vcnt_reg + 11'd1;
    end
  end

  // Activity is judged on the post-update counts so the sync-edge pixel is slot 0
  assign col        = hcnt_next - H_START;
  assign line       = vcnt_next - V_START;
  assign active_pix = strobe
                      && (hcnt_next >= H_START) && (hcnt_next < H_STOP)
                      && (vcnt_next >= V_START) && (vcnt_next < V_STOP);
  assign cap_pix    = active_pix && (state_reg == CAPTURE);
  assign is_last    = (col == LAST_COL) && (line == LAST_LINE);
  assign addr_next  = ADDR_W'(line) * ADDR_W'(H_ACTIVE) + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (cap_en)
          state_next = WAIT_VS;
      end
      WAIT_VS: begin
        if (!cap_en)
          state_next = IDLE;
        else if (vfall)
          state_next = CAPTURE;
      end
      CAPTURE: begin
        // A vfall here just restarts the frame; only completion leaves CAPTURE
        if (last_reg)
          state_next = cap_en ? WAIT_VS : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vclk_q         <= 1'b0;
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      hcnt_reg       <= '0;
      vcnt_reg       <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      last_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_sum_reg  <= '0;
      frame_cnt_reg  <= '0;
      acc_reg        <= '0;
    end else begin
      vclk_q   <= vga_clk;
      hcnt_reg <= hcnt_next;
      vcnt_reg <= vcnt_next;
      if (strobe) begin
        hs_q <= h_sync;
        vs_q <= v_sync;
      end

      wr_en_reg <= cap_pix;
      last_reg  <= cap_pix && is_last;
      if (cap_pix) begin
        wr_addr_reg <= addr_next;
        wr_data_reg <= rgb;
      end

      frame_done_reg <= last_reg;
      if (last_reg) begin
        frame_sum_reg <= acc_reg;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end

      // Strobes are never back to back, so cap_pix and last_reg are exclusive
      if (vfall && (state_reg != IDLE))
        acc_reg <= '0;
      else if (cap_pix)
        acc_reg <= acc_reg + {8'h00, rgb};
      else if (last_reg)
        acc_reg <= '0;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign frame_done = frame_done_reg;
  assign frame_sum  = frame_sum_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign busy       = (state_reg != IDLE);

`ifdef VGA_CAP_ERR_EN
  localparam logic [12:0] H_TOTAL = 13'(H_FP + H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_TOTAL = 12'(V_FP + V_SYNC + V_BP + V_ACTIVE);

  logic h_seen_reg, v_seen_reg, h_err_reg, v_err_reg;
  logic h_bad, v_bad;

  // Counts are compared before they reset, so the sync-edge slot makes up the +1
  assign h_bad = hfall && h_seen_reg && (({1'b0, hcnt_reg} + 13'd1) != H_TOTAL);
  assign v_bad = vfall && v_seen_reg && (({1'b0, vcnt_reg} + 12'd1) != V_TOTAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_seen_reg <= 1'b0;
      v_seen_reg <= 1'b0;
      h_err_reg  <= 1'b0;
      v_err_reg  <= 1'b0;
    end else begin
      if (hfall) h_seen_reg <= 1'b1;
      if (vfall) v_seen_reg <= 1'b1;
      if (h_bad)        h_err_reg <= 1'b1;
      else if (err_clr) h_err_reg <= 1'b0;
      if (v_bad)        v_err_reg <= 1'b1;
      else if (err_clr) v_err_reg <= 1'b0;
    end
  end

  assign h_err = h_err_reg;
  assign v_err = v_err_reg;
`else
  logic unused_cfg;
  assign unused_cfg = ^{err_clr, 12'(H_FP), 11'(V_FP)};
  assign h_err = 1'b0;
  assign v_err = 1'b0;
`endif

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receiving end of the ASIP VGA output (rgb, h_sync, v_sync, vga_clk).
- Recovers pixel timing from the sync pulses and writes every active pixel of a frame to a frame-buffer write port.
- Accumulates a per-frame checksum and counts frames, so benches and on-board self-test can check rendered images without a monitor.
- Runs in the system clk domain; vga_clk is sampled as data and is never used as a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, h_sync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, v_sync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- vga_clk  in  1  pixel clock from the VGA generator, sampled in clk
- h_sync  in  1  horizontal sync, active-low
- v_sync  in  1  vertical sync, active-low
- rgb  in  24  pixel data {R[23:16], G[15:8], B[7:0]}
- cap_en  in  1  level; request capture of frames
- err_clr  in  1  one-cycle pulse; clears sticky errors
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  line*H_ACTIVE + column
- wr_data  out  24  captured rgb
- frame_done  out  1  one-cycle pulse at the end of a captured frame
- frame_sum  out  32  checksum of the last completed frame
- frame_cnt  out  16  number of completed frames, wraps modulo 2^16
- busy  out  1  high while in WAIT_VS or CAPTURE
- h_err  out  1  sticky: line length mismatch
- v_err  out  1  sticky: frame length mismatch

Behaviour:
- Reset: all outputs 0, internal counters and checksum accumulator 0, state IDLE. Reset takes effect mid-frame with no write or pulse completing.
- Strobe: vga_clk is registered once (vclk_q). strobe = vga_clk & ~vclk_q.
  - All sampling happens only on strobe cycles.
  - h_sync, v_sync and rgb are taken on the same strobe and registered as hs_q / vs_q.
- Edges: hfall = strobe & ~h_sync & hs_q. vfall = strobe & ~v_sync & vs_q.
- Horizontal counter hcnt (12 bits):
  - On hfall: hcnt <= 0.
  - On any other strobe: hcnt <= hcnt+1, saturating at 4095.
- Vertical counter vcnt (11 bits):
  - On vfall: vcnt <= 0.
  - On an hfall without vfall: vcnt <= vcnt+1, saturating.
  - vfall takes priority over hfall when both occur on the same strobe.
- Active pixel: a strobe where, after the update above,
  - H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE, and
  - V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE.
  - col = hcnt-(H_SYNC+H_BP); line = vcnt-(V_SYNC+V_BP).
- FSM states: IDLE, WAIT_VS, CAPTURE.
  - IDLE -> WAIT_VS when cap_en=1.
  - WAIT_VS -> CAPTURE on vfall. If cap_en drops while in WAIT_VS, return to IDLE.
  - CAPTURE: each active pixel at cycle N gives, at cycle N+1: wr_en=1, wr_addr=line*H_ACTIVE+col, wr_data=rgb. The checksum accumulator adds {8'h00,rgb} modulo 2^32.
  - After the write of the last active pixel (line=V_ACTIVE-1, col=H_ACTIVE-1), the next cycle gives:
    - frame_done=1 for exactly one cycle;
    - frame_sum <= final accumulator value;
    - frame_cnt <= frame_cnt+1;
    - accumulator <= 0.
  - Then go to WAIT_VS if cap_en=1, else IDLE.
  - cap_en dropping during CAPTURE does not abort: the current frame completes.
  - A vfall seen during CAPTURE before the frame completes is a truncated frame: accumulator <= 0, no frame_done, stay in CAPTURE (restart capture of the new frame).
- wr_en is 0 outside CAPTURE. wr_addr and wr_data hold their last values when wr_en=0.
- No writes ever occur for pixels seen before the first vfall after cap_en rose.

Optional Feature:
- Macro: VGA_CAP_ERR_EN.
- Defined:
  - On hfall, when a previous hfall has been seen since reset: if hcnt+1 != H_FP+H_SYNC+H_BP+H_ACTIVE, set h_err.
  - On vfall, when a previous vfall has been seen: if vcnt+1 != V_FP+V_SYNC+V_BP+V_ACTIVE, set v_err.
  - Both flags are sticky and cleared by rst or err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- Not defined: h_err and v_err are tied to 0, err_clr is ignored, and no checking logic is synthesized.

Test Plan:
1. Reset: rst=1 for 3 cycles with toggling VGA inputs -> all outputs 0, state IDLE, no wr_en.
2. Small-frame capture: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1; cap_en=1; rgb = pixel index 0..11 on active pixels.
   - Expect 12 writes with wr_addr 0..11 and wr_data 0..11.
   - Then frame_done for one cycle, frame_sum=66, frame_cnt=1.
3. cap_en dropped in the middle of line 1 -> frame completes with 12 writes and frame_done. State then IDLE, and there are no writes in the next frame.
4. cap_en raised mid-frame -> zero writes until the next vfall, then a full 12-write frame.
5. Truncated frame: vfall injected after 5 writes -> no frame_done. The next full frame gives frame_sum=66 and frame_cnt=1.
6. With VGA_CAP_ERR_EN defined: one line shortened to 7 pixels -> h_err=1 after that hfall. err_clr pulse -> h_err=0. Without the macro, h_err stays 0.
